spi_log_serializer: RTL and testbench
=====================================

Name: spi_log_serializer

Overview:
- Sits between the spi_flash logging interface and the uart transmitter.
- Queues SPI read-log events (address, length) in a FIFO so bursts during boot are not lost.
- Serialises each event as a fixed 4-byte frame to the uart, and merges the serial user-interface byte stream onto the same uart with fair arbitration.
- Reports dropped events when the FIFO overflows.

Parameters:
- FIFO_DEPTH, 16, number of queued log entries; power of two, minimum 2.
- DROP_WIDTH, 16, width of the saturating dropped-event counter.

Ports:
- clk  input  1  system clock (132 MHz domain)
- reset  input  1  asynchronous, active-high reset
- log_strobe  input  1  single-cycle pulse; a SPI transaction log entry is valid
- log_addr  input  32  transaction start address; only [23:0] is used
- log_len  input  8  transaction byte count
- user_txd  input  8  byte from the user command parser
- user_txd_strobe  input  1  user byte valid; accepted only when user_txd_ready=1
- user_txd_ready  output  1  holding register empty; user byte may be offered
- uart_txd  output  8  byte to the uart
- uart_txd_strobe  output  1  single-cycle transmit pulse
- uart_txd_ready  input  1  uart FIFO has space
- drop_clear  input  1  synchronous clear of drop_count
- drop_count  output  DROP_WIDTH  saturating count of discarded log events
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current number of queued entries

Behaviour:
Reset values:
- uart_txd_strobe=0, uart_txd=0, user_txd_ready=1, drop_count=0, fifo_level=0.
- FIFO pointers 0, user holding register empty, state IDLE.

FIFO:
- Entry is 32 bits, {log_addr[23:0], log_len}.
- A write occurs on log_strobe when the FIFO is not full.
- Fullness is evaluated on the pre-cycle state. A log_strobe while full is dropped even if a pop occurs in the same cycle.
- A drop increments drop_count, saturating at all-ones.
- drop_clear zeroes drop_count. If drop_clear coincides with a drop, the result is 1.
- Simultaneous push and pop leaves fifo_level unchanged.
- Pointers wrap modulo FIFO_DEPTH.

User holding register:
- When user_txd_strobe and user_txd_ready are both high, latch user_txd and drop user_txd_ready on the next cycle.
- user_txd_ready returns to 1 the cycle after the held byte is transmitted.
- A user_txd_strobe while user_txd_ready=0 is ignored.

State machine (IDLE, LOAD, SEND, GAP):
- IDLE → LOAD when the FIFO is non-empty and the previous grant was not log-with-user-pending. The pop happens in this cycle; the entry is latched into a 32-bit shift register and byte index 0 is set.
- IDLE → SEND(user) when the user byte is held and either the FIFO is empty or the last completed frame was a log frame. This is round-robin at frame granularity: one user byte between consecutive log frames.
- LOAD → SEND(log).
- SEND: when uart_txd_ready=1, assert uart_txd_strobe for exactly one cycle.
  - For a log frame, uart_txd = shift[31:24], then shift left 8 and increment the byte index.
  - For a user frame, uart_txd = the held byte.
  - Then go to GAP.
  - While uart_txd_ready=0, stay in SEND with strobe low and no data change.
- GAP (exactly one cycle, lets uart_txd_ready update after a strobe):
  - Go to SEND if a log frame has bytes remaining (index < 4).
  - Otherwise go to IDLE.

Frame rules:
- Log frame byte order on the wire is addr[23:16], addr[15:8], addr[7:0], len.
- Frames are atomic; no user byte is interleaved inside a log frame.
- Minimum spacing between strobes is 2 cycles.
- uart_txd holds its last value when the strobe is low.

Latency:
- With the block idle, the FIFO empty and uart_txd_ready=1, a log_strobe at cycle N gives the first uart_txd_strobe at N+3 (push N, IDLE sees non-empty N+1, LOAD N+2, SEND N+3).
- The remaining bytes follow at N+5, N+7 and N+9.

Reset mid-frame:
- Abort immediately; the frame is lost.
- The FIFO and holding register are emptied and no further strobes occur.

Test Plan:
- Single log_strobe, addr=0x12ABCDEF, len=0x40, ready held 1 → strobes at N+3/5/7/9 with bytes 0xAB, 0xCD, 0xEF, 0x40; fifo_level 1 then 0.
- Burst of FIFO_DEPTH+3 back-to-back log_strobes with ready held 0 → fifo_level=16, drop_count=3. Then ready=1 → 16 frames in order, 64 bytes, no corruption.
- Held user byte 0x55 while 3 log entries are queued → wire order is frame0, 0x55, frame1, frame2. user_txd_ready low until the cycle after 0x55 is sent.
- uart_txd_ready deasserted after byte 1 of a frame for 10 cycles → no strobes during the stall. Bytes 2 and 3 resume unchanged, and no user byte is interleaved.
- drop_count at 0xFFFF plus another overflow → stays 0xFFFF. drop_clear coincident with a drop → 1.
- Reset asserted between byte 1 and byte 2 of a frame → strobe low immediately; after release, outputs are at reset values and no residual bytes are sent.

Source files
------------

// File: rtl/spi_log_serializer.sv
// -----------------------------------------------------------------------------
// spi_log_serializer
//
// Queues SPI flash read-log events and sends each one to the uart as a 4-byte
// frame: addr[23:16], addr[15:8], addr[7:0], len. Bytes from the user command
// parser share the same uart. When both sources are waiting, they alternate
// one frame at a time. Log events that arrive while the queue is full are
// counted in a saturating drop counter.
//
// Ports
//   clk              system clock
//   reset            asynchronous, active-high reset
//   log_strobe       one-cycle pulse: {log_addr, log_len} is a valid event
//   log_addr         transaction start address (only [23:0] is kept)
//   log_len          transaction byte count
//   user_txd         user byte, accepted when user_txd_strobe && user_txd_ready
//   user_txd_strobe  user byte valid
//   user_txd_ready   user holding register is empty
//   uart_txd         byte to the uart; holds its last value between strobes
//   uart_txd_strobe  one-cycle transmit pulse
//   uart_txd_ready   uart has space for a byte
//   drop_clear       synchronous clear of drop_count
//   drop_count       saturating count of discarded log events
//   fifo_level       number of queued log events
// -----------------------------------------------------------------------------
module spi_log_serializer #(
   parameter int FIFO_DEPTH = 16,   // power of two, >= 2
   parameter int DROP_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          log_strobe,
   input  logic [31:0]                   log_addr,
   input  logic [7:0]                    log_len,
   input  logic [7:0]                    user_txd,
   input  logic                          user_txd_strobe,
   output logic                          user_txd_ready,
   output logic [7:0]                    uart_txd,
   output logic                          uart_txd_strobe,
   input  logic                          uart_txd_ready,
   input  logic                          drop_clear,
   output logic [DROP_WIDTH-1:0]         drop_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_e;

   // ---------------------------------------------------------------- FIFO
   logic [31:0]           mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]         level_q, level_d;
   logic                  fifo_full, fifo_empty;
   logic                  push, pop, drop;

   // ---------------------------------------------------------------- control
   state_e                state_q;
   logic                  is_user_q;     // frame in flight is a user byte
   logic                  last_log_q;    // last completed frame was a log frame
   logic [31:0]           shift_q;
   logic [2:0]            idx_q;
   logic [7:0]            txd_last_q;
   logic                  user_held_q;
   logic [7:0]            user_byte_q;
   logic [DROP_WIDTH-1:0] drop_q;
   logic                  grant_user;
   logic                  send_fire;
   logic [7:0]            tx_byte;

   // The top address byte is not part of the log frame.
   logic                  unused_addr_hi;
   assign unused_addr_hi = ^log_addr[31:24];

   // Fullness is taken from the pre-cycle level, so a strobe into a full FIFO
   // is dropped even if an entry leaves in the same cycle.
   assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
   assign fifo_empty = (level_q == '0);
   assign push       = log_strobe && !fifo_full;
   assign drop       = log_strobe && fifo_full;

   // Round-robin at frame granularity: a held user byte goes next unless a
   // log frame is waiting and the last completed frame was not a log frame.
   assign grant_user = (state_q == IDLE) && user_held_q && (fifo_empty || last_log_q);
   assign pop        = (state_q == IDLE) && !fifo_empty && !grant_user;

   // The strobe follows uart_txd_ready in the same cycle so that a SEND with
   // the uart ready costs no extra cycle; data is muxed only while strobing.
   assign send_fire       = (state_q == SEND) && uart_txd_ready;
   assign tx_byte         = is_user_q ? user_byte_q : shift_q[31:24];
   assign uart_txd_strobe = send_fire;
   assign uart_txd        = send_fire ? tx_byte : txd_last_q;

   assign user_txd_ready  = !user_held_q;
   assign drop_count      = drop_q;
   assign fifo_level      = level_q;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // NOTE: the storage array has no reset; only pointers and level do, which
   // is enough to make its contents irrelevant after reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= {log_addr[23:0], log_len};
   end

   // NOTE: clocked state uses non-blocking assignments only, so every block
   // sees pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);   // wraps modulo depth
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end

   // Saturating drop counter; a clear that coincides with a drop yields 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_q <= '0;
      end else if (drop_clear) begin
         drop_q <= drop ? DROP_WIDTH'(1) : '0;
      end else if (drop && (drop_q != '1)) begin
         drop_q <= drop_q + DROP_WIDTH'(1);
      end
   end

   // User holding register; empties when its byte is strobed out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         user_held_q <= 1'b0;
         user_byte_q <= '0;
      end else if (user_txd_strobe && !user_held_q) begin
         user_held_q <= 1'b1;
         user_byte_q <= user_txd;
      end else if (send_fire && is_user_q) begin
         user_held_q <= 1'b0;
      end
   end

   // Frame sequencer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         is_user_q  <= 1'b0;
         last_log_q <= 1'b0;
         shift_q    <= '0;
         idx_q      <= '0;
         txd_last_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_user) begin
                  is_user_q <= 1'b1;
                  state_q   <= SEND;
               end else if (!fifo_empty) begin
                  is_user_q <= 1'b0;
                  shift_q   <= mem[rd_ptr_q];
                  idx_q     <= '0;
                  state_q   <= LOAD;
               end
            end
            LOAD: state_q <= SEND;
            SEND: begin
               if (uart_txd_ready) begin
                  txd_last_q <= tx_byte;
                  if (!is_user_q) begin
                     shift_q <= {shift_q[23:0], 8'h00};
                     idx_q   <= idx_q + 3'd1;
                  end
                  state_q <= GAP;
               end
            end
            GAP: begin
               // One idle cycle lets uart_txd_ready reflect the last strobe.
               if (!is_user_q && (idx_q < 3'd4)) begin
                  state_q <= SEND;
               end else begin
                  last_log_q <= !is_user_q;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_log_serializer.sv
// -----------------------------------------------------------------------------
// tb_spi_log_serializer
//
// Directed bench for spi_log_serializer. Inputs change 1 time unit after a
// rising edge; outputs are sampled on the falling edge. A second, small
// instance (depth 2, 4-bit drop counter) covers drop-counter saturation.
// -----------------------------------------------------------------------------
module tb_spi_log_serializer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        log_strobe;
   logic [31:0] log_addr;
   logic [7:0]  log_len;
   logic [7:0]  user_txd;
   logic        user_txd_strobe;
   logic        user_txd_ready;
   logic [7:0]  uart_txd;
   logic        uart_txd_strobe;
   logic        uart_txd_ready;
   logic        drop_clear;
   logic [15:0] drop_count;
   logic [4:0]  fifo_level;

   // small instance for saturation
   logic        s_log_strobe;
   logic        s_user_strobe;
   logic        s_uart_ready;
   logic        s_drop_clear;
   logic [3:0]  s_drop_count;
   logic [1:0]  s_fifo_level;
   logic        s_unused_user_ready;
   logic [7:0]  s_unused_txd;
   logic        s_unused_strobe;

   spi_log_serializer #(.FIFO_DEPTH(16), .DROP_WIDTH(16)) u_dut (
      .clk             (clk),
      .reset           (reset),
      .log_strobe      (log_strobe),
      .log_addr        (log_addr),
      .log_len         (log_len),
      .user_txd        (user_txd),
      .user_txd_strobe (user_txd_strobe),
      .user_txd_ready  (user_txd_ready),
      .uart_txd        (uart_txd),
      .uart_txd_strobe (uart_txd_strobe),
      .uart_txd_ready  (uart_txd_ready),
      .drop_clear      (drop_clear),
      .drop_count      (drop_count),
      .fifo_level      (fifo_level)
   );

   spi_log_serializer #(.FIFO_DEPTH(2), .DROP_WIDTH(4)) u_dut_sat (
      .clk             (clk),
      .reset           (reset),
      .log_strobe      (s_log_strobe),
      .log_addr        (log_addr),
      .log_len         (log_len),
      .user_txd        (user_txd),
      .user_txd_strobe (s_user_strobe),
      .user_txd_ready  (s_unused_user_ready),
      .uart_txd        (s_unused_txd),
      .uart_txd_strobe (s_unused_strobe),
      .uart_txd_ready  (s_uart_ready),
      .drop_clear      (s_drop_clear),
      .drop_count      (s_drop_count),
      .fifo_level      (s_fifo_level)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // capture of every uart strobe: byte and cycle number
   logic [7:0] cap_byte [$];
   int         cap_cyc  [$];
   always @(negedge clk) begin
      if (uart_txd_strobe === 1'b1) begin
         cap_byte.push_back(uart_txd);
         cap_cyc.push_back(cyc);
      end
   end

   // first cycle user_txd_ready is seen high while armed
   bit arm_rise = 1'b0;
   int rise_cyc = -1;
   always @(negedge clk) begin
      if (!arm_rise)                                 rise_cyc = -1;
      else if (user_txd_ready === 1'b1 && rise_cyc < 0) rise_cyc = cyc;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_bytes(input int base, input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (cap_byte.size() - base >= n) break;
         next_cycle();
      end
   endtask

   // distinct log entry {addr[23:0], len} for index i
   function automatic logic [31:0] ent(input int i);
      logic [7:0] b;
      b = i[7:0];
      return {b ^ 8'h3C, b + 8'h80, ~b, b * 8'd7 + 8'd1};
   endfunction

   task automatic drive_log(input logic [31:0] e);
      log_addr   = {8'hFF, e[31:8]};
      log_len    = e[7:0];
      log_strobe = 1'b1;
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          base, n0, p0;
      logic [31:0] e;
      logic [7:0]  exp_b [$];
      logic [7:0]  t1_exp [4];

      reset = 1'b1; log_strobe = 1'b0; log_addr = '0; log_len = '0;
      user_txd = '0; user_txd_strobe = 1'b0; uart_txd_ready = 1'b1; drop_clear = 1'b0;
      s_log_strobe = 1'b0; s_user_strobe = 1'b0; s_uart_ready = 1'b0; s_drop_clear = 1'b0;

      // ---- reset values
      repeat (3) next_cycle();
      check("rst_strobe", uart_txd_strobe, 1'b0);
      check("rst_txd", uart_txd, 8'h00);
      check("rst_user_ready", user_txd_ready, 1'b1);
      check("rst_drop", drop_count, 16'h0);
      check("rst_level", fifo_level, 5'd0);
      reset = 1'b0;
      next_cycle();

      // ---- single event: latency and byte order
      base = cap_byte.size();
      log_addr = 32'h12ABCDEF; log_len = 8'h40; log_strobe = 1'b1;
      n0 = cyc;
      next_cycle();
      log_strobe = 1'b0;
      @(negedge clk);
      check("t1_level_n1", fifo_level, 5'd1);
      next_cycle();
      @(negedge clk);
      check("t1_level_n2", fifo_level, 5'd0);
      repeat (12) next_cycle();
      t1_exp = '{8'hAB, 8'hCD, 8'hEF, 8'h40};
      check("t1_count", cap_byte.size() - base, 4);
      if (cap_byte.size() - base >= 4) begin
         for (int k = 0; k < 4; k++) begin
            check($sformatf("t1_byte%0d", k), cap_byte[base + k], t1_exp[k]);
            check($sformatf("t1_cyc%0d", k), cap_cyc[base + k] - n0, 3 + 2 * k);
         end
      end
      @(negedge clk);
      check("t1_txd_hold", uart_txd, 8'h40);

      // ---- overflow burst behind a stalled user byte
      uart_txd_ready = 1'b0;
      user_txd = 8'hA5; user_txd_strobe = 1'b1;
      next_cycle();
      user_txd_strobe = 1'b0;
      next_cycle();
      next_cycle();
      base = cap_byte.size();
      for (int i = 0; i < 19; i++) begin
         drive_log(ent(i));
         next_cycle();
      end
      log_strobe = 1'b0;
      @(negedge clk);
      check("t2_level_full", fifo_level, 5'd16);
      check("t2_drops", drop_count, 16'd3);
      check("t2_user_ready", user_txd_ready, 1'b0);
      check("t2_no_strobe", cap_byte.size() - base, 0);
      uart_txd_ready = 1'b1;
      wait_bytes(base, 65, 400);
      repeat (10) next_cycle();
      check("t2_count", cap_byte.size() - base, 65);
      if (cap_byte.size() - base >= 65) begin
         check("t2_user", cap_byte[base], 8'hA5);
         for (int i = 0; i < 16; i++) begin
            e = ent(i);
            for (int k = 0; k < 4; k++)
               check($sformatf("t2_f%0d_b%0d", i, k), cap_byte[base + 1 + 4 * i + k], e[31 - 8 * k -: 8]);
         end
      end
      check("t2_level_empty", fifo_level, 5'd0);
      drop_clear = 1'b1;
      next_cycle();
      drop_clear = 1'b0;
      @(negedge clk);
      check("t2_drop_clear", drop_count, 16'd0);

      // ---- fairness: frame0, user byte, frame1, frame2
      reset = 1'b1;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      next_cycle();
      base = cap_byte.size();
      p0 = cyc;
      drive_log(ent(40));
      user_txd = 8'h55; user_txd_strobe = 1'b1;
      next_cycle();
      user_txd_strobe = 1'b0;
      arm_rise = 1'b1;
      drive_log(ent(41));
      next_cycle();
      drive_log(ent(42));
      next_cycle();
      log_strobe = 1'b0;
      wait_bytes(base, 13, 100);
      repeat (5) next_cycle();
      exp_b.delete();
      for (int k = 0; k < 4; k++) begin e = ent(40); exp_b.push_back(e[31 - 8 * k -: 8]); end
      exp_b.push_back(8'h55);
      for (int i = 41; i < 43; i++)
         for (int k = 0; k < 4; k++) begin e = ent(i); exp_b.push_back(e[31 - 8 * k -: 8]); end
      check("t3_count", cap_byte.size() - base, 13);
      if (cap_byte.size() - base >= 13) begin
         for (int k = 0; k < 13; k++)
            check($sformatf("t3_byte%0d", k), cap_byte[base + k], exp_b[k]);
         check("t3_user_cyc", cap_cyc[base + 4] - p0, 12);
      end
      check("t3_ready_rise", rise_cyc - p0, 13);
      arm_rise = 1'b0;

      // ---- uart stall mid-frame, user byte offered during the stall
      base = cap_byte.size();
      n0 = cyc;
      drive_log(ent(50));
      next_cycle();
      log_strobe = 1'b0;
      next_cycle();
      next_cycle();
      next_cycle();
      uart_txd_ready = 1'b0;
      user_txd = 8'h77; user_txd_strobe = 1'b1;
      next_cycle();
      user_txd_strobe = 1'b0;
      while (cyc < n0 + 14) next_cycle();
      uart_txd_ready = 1'b1;
      wait_bytes(base, 5, 60);
      repeat (5) next_cycle();
      check("t4_count", cap_byte.size() - base, 5);
      if (cap_byte.size() - base >= 5) begin
         e = ent(50);
         for (int k = 0; k < 4; k++)
            check($sformatf("t4_byte%0d", k), cap_byte[base + k], e[31 - 8 * k -: 8]);
         check("t4_user", cap_byte[base + 4], 8'h77);
         check("t4_cyc0", cap_cyc[base]     - n0, 3);
         check("t4_cyc1", cap_cyc[base + 1] - n0, 14);
         check("t4_cyc2", cap_cyc[base + 2] - n0, 16);
         check("t4_cyc3", cap_cyc[base + 3] - n0, 18);
         check("t4_cyc4", cap_cyc[base + 4] - n0, 21);
      end

      // ---- drop counter saturation and clear-with-drop (small instance)
      s_log_strobe = 1'b1;
      repeat (18) next_cycle();
      @(negedge clk);
      check("t5_level", s_fifo_level, 2'd2);
      check("t5_drop_max", s_drop_count, 4'hF);
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("t5_drop_sat", s_drop_count, 4'hF);
      s_drop_clear = 1'b1;
      next_cycle();
      s_drop_clear = 1'b0;
      s_log_strobe = 1'b0;
      @(negedge clk);
      check("t5_clear_with_drop", s_drop_count, 4'h1);
      s_drop_clear = 1'b1;
      next_cycle();
      s_drop_clear = 1'b0;
      @(negedge clk);
      check("t5_clear", s_drop_count, 4'h0);

      // ---- reset between the first and second byte of a frame
      next_cycle();
      base = cap_byte.size();
      drive_log(ent(60));
      next_cycle();
      drive_log(ent(61));
      user_txd = 8'h99; user_txd_strobe = 1'b1;
      next_cycle();
      log_strobe = 1'b0;
      user_txd_strobe = 1'b0;
      next_cycle();
      next_cycle();
      next_cycle();
      reset = 1'b1;
      #1;
      check("t6_strobe_now", uart_txd_strobe, 1'b0);
      @(negedge clk);
      check("t6_strobe_neg", uart_txd_strobe, 1'b0);
      check("t6_sent_before", cap_byte.size() - base, 1);
      next_cycle();
      next_cycle();
      reset = 1'b0;
      next_cycle();
      @(negedge clk);
      check("t6_level", fifo_level, 5'd0);
      check("t6_user_ready", user_txd_ready, 1'b1);
      check("t6_drop", drop_count, 16'd0);
      check("t6_txd", uart_txd, 8'h00);
      check("t6_strobe", uart_txd_strobe, 1'b0);
      base = cap_byte.size();
      repeat (30) next_cycle();
      check("t6_no_residual", cap_byte.size() - base, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
